// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the issue stage and the HI/LO multiply-divide unit.
// The master drives requests; the slave returns status, HI/LO and mfhi/mflo read data.
interface mul_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [5:0]       funct;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             stall;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] rd_data;

   modport master (
      output start, funct, op_a, op_b,
      input  busy, stall, done, div_zero, hi, lo, rd_data
   );

   modport slave (
      input  start, funct, op_a, op_b,
      output busy, stall, done, div_zero, hi, lo, rd_data
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style HI/LO unit: shift-add multiply, restoring divide,
// fixed latency of WIDTH+2 edges from accept to the done pulse.
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic           clock,
   input logic           reset_n,
   mul_div_unit_if.slave bus
);

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1a;
   localparam logic [5:0] F_DIVU  = 6'h1b;

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opReg;
   logic [WIDTH-1:0]   hiQ;
   logic [WIDTH-1:0]   loQ;
   logic               negQ;
   logic               negR;
   logic               zeroDiv;
   logic               isDivOp;
   logic               doneQ;
   logic               divZeroQ;

   logic               isSigned;
   logic               isMulF;
   logic               isDivF;
   logic               isMthi;
   logic               isMtlo;
   logic               lastIter;
   logic [WIDTH-1:0]   aAbs;
   logic [WIDTH-1:0]   bAbs;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     divTrial;
   logic [WIDTH:0]     divDiff;
   logic [2*WIDTH-1:0] mulNext;
   logic [2*WIDTH-1:0] divNext;
   logic [2*WIDTH-1:0] fixed;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;

   assign isMulF   = bus.funct == F_MULT || bus.funct == F_MULTU;
   assign isDivF   = bus.funct == F_DIV || bus.funct == F_DIVU;
   assign isMthi   = bus.funct == F_MTHI;
   assign isMtlo   = bus.funct == F_MTLO;
   assign isSigned = bus.funct == F_MULT || bus.funct == F_DIV;
   assign lastIter = cnt == CNT_W'(WIDTH - 1);

   assign aAbs = (isSigned && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
   assign bAbs = (isSigned && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;

   // multiplier lives in the low half of acc and is consumed LSB first
   assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc[0] ? opReg : {WIDTH{1'b0}})};
   assign mulNext = {mulSum, acc[WIDTH-1:1]};

   // dividend shifts out of the low half; quotient bits shift in behind it
   assign divTrial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign divDiff  = divTrial - {1'b0, opReg};
   assign divNext  = divDiff[WIDTH]
                   ? {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                   : {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   always_comb begin
      quot  = acc[WIDTH-1:0];
      rem   = acc[2*WIDTH-1:WIDTH];
      fixed = acc;
      if (isDivOp) begin
         if (zeroDiv)
            quot = '1;
         else if (negQ)
            quot = -acc[WIDTH-1:0];
         if (negR)
            rem = -acc[2*WIDTH-1:WIDTH];
         fixed = {rem, quot};
      end else if (negQ) begin
         fixed = -acc;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         opReg    <= '0;
         hiQ      <= '0;
         loQ      <= '0;
         negQ     <= 1'b0;
         negR     <= 1'b0;
         zeroDiv  <= 1'b0;
         isDivOp  <= 1'b0;
         doneQ    <= 1'b0;
         divZeroQ <= 1'b0;
      end else begin
         doneQ    <= 1'b0;
         divZeroQ <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  unique case (1'b1)
                     isMulF: begin
                        opReg   <= aAbs;
                        acc     <= {{WIDTH{1'b0}}, bAbs};
                        negQ    <= isSigned & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        negR    <= 1'b0;
                        zeroDiv <= 1'b0;
                        isDivOp <= 1'b0;
                        cnt     <= '0;
                        state   <= MUL;
                     end
                     isDivF: begin
                        opReg   <= bAbs;
                        acc     <= {{WIDTH{1'b0}}, aAbs};
                        negQ    <= isSigned & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        negR    <= isSigned & bus.op_a[WIDTH-1];
                        zeroDiv <= bus.op_b == '0;
                        isDivOp <= 1'b1;
                        cnt     <= '0;
                        state   <= DIV;
                     end
                     isMthi: hiQ <= bus.op_a;
                     isMtlo: loQ <= bus.op_a;
                     default: ;
                  endcase
               end
            end
            MUL: begin
               acc <= mulNext;
               cnt <= cnt + CNT_W'(1);
               if (lastIter)
                  state <= FIXUP;
            end
            DIV: begin
               acc <= divNext;
               cnt <= cnt + CNT_W'(1);
               if (lastIter)
                  state <= FIXUP;
            end
            FIXUP: begin
               acc   <= fixed;
               state <= DONE;
            end
            DONE: begin
               hiQ      <= acc[2*WIDTH-1:WIDTH];
               loQ      <= acc[WIDTH-1:0];
               doneQ    <= 1'b1;
               divZeroQ <= zeroDiv;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = state != IDLE;
   assign bus.stall    = bus.start & (state != IDLE);
   assign bus.done     = doneQ;
   assign bus.div_zero = divZeroQ;
   assign bus.hi       = hiQ;
   assign bus.lo       = loQ;
   assign bus.rd_data  = (bus.funct == F_MFHI) ? hiQ
                       : (bus.funct == F_MFLO) ? loQ
                       : '0;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width (even, >=8).
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width (2^CNT_W > WIDTH).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request valid this cycle.
REQ-007 funct  input  6  R-type function code selecting operation.
REQ-008 op_a  input  WIDTH  rs operand (multiplicand/dividend; mthi/mtlo source).
REQ-009 op_b  input  WIDTH  rt operand (multiplier/divisor).
REQ-010 busy  output  1  iterative operation in progress.
REQ-011 stall  output  1  start asserted while busy; request not accepted.
REQ-012 done  output  1  one-cycle pulse when HI/LO take a mult/div result.
REQ-013 div_zero  output  1  valid with done; divisor was zero.
REQ-014 hi  output  WIDTH  HI register.
REQ-015 lo  output  WIDTH  LO register.
REQ-016 rd_data  output  WIDTH  combinational: hi when funct=0x10 (mfhi), lo when 0x12 (mflo), else 0.

Function
REQ-017 Ops: 0x18 mult, 0x19 multu, 0x1a div, 0x1b divu, 0x11 mthi, 0x13 mtlo; other funct with start SHALL cause no state change.
REQ-018 FSM states IDLE, MUL, DIV, FIXUP, DONE; busy=1 in MUL, DIV, FIXUP, DONE.
REQ-019 Request accepted only on a rising edge with start=1 in IDLE; start in any other state SHALL be ignored and raise stall that cycle (stall=start&busy).
REQ-020 mthi/mtlo accepted in IDLE SHALL write op_a into hi/lo on that edge; FSM stays IDLE; no done.
REQ-021 mult/div accepted: operands captured; signed ops capture absolute values and record result signs; FSM -> MUL or DIV, counter=0.
REQ-022 MUL: unsigned shift-add, one multiplier bit per cycle, exactly WIDTH cycles into a 2*WIDTH accumulator, then -> FIXUP.
REQ-023 DIV: restoring division, one quotient bit per cycle, exactly WIDTH cycles, then -> FIXUP.
REQ-024 FIXUP (1 cycle): signed mult negates 2*WIDTH product if operand signs differ; signed div negates quotient if signs differ, remainder takes sign of dividend; -> DONE.
REQ-025 DONE (1 cycle): hi/lo load result (mult: hi=upper, lo=lower; div: hi=remainder, lo=quotient), done=1, -> IDLE.
REQ-026 Latency SHALL be fixed: done high in the cycle WIDTH+2 edges after the accept edge, for all four ops and all operand values.
REQ-027 hi/lo SHALL hold previous values throughout MUL/DIV/FIXUP; back-to-back op SHALL be accepted on the edge leaving DONE->IDLE at earliest, i.e. the cycle after done.
REQ-028 Divisor zero: iterations still run (fixed latency); result lo={WIDTH{1}}, hi=op_a as captured (unsigned or signed); div_zero=1 with done.
REQ-029 Signed div of most-negative by -1: lo=most-negative, hi=0, div_zero=0 (modulo-2^WIDTH wrap, no trap).
REQ-030 div_zero SHALL be 0 whenever done=0.
REQ-031 All arithmetic modulo 2^WIDTH per register; no overflow signal.

Reset
REQ-032 reset_n low SHALL immediately force: state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, div_zero=0, stall=start&0=0.
REQ-033 Reset mid-operation SHALL abandon the op; no done afterwards; first edge after release with start=1 in IDLE is accepted.

Verification (WIDTH=32)
REQ-034 multu 0xFFFFFFFF x 0xFFFFFFFF -> done 34 cycles after accept, hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 mult 0xFFFFFFFD(-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; rd_data with funct=0x12 = 0xFFFFFFF1.
REQ-036 div 0xFFFFFFF9(-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 0x64 / 0 -> lo=0xFFFFFFFF, hi=0x64, div_zero=1 for one cycle.
REQ-037 div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-038 start mult at t0; start divu at t0+5 -> stall=1 that cycle, divu ignored, only mult result appears; mthi 0x1234 in IDLE -> hi=0x1234 next edge, no done.
REQ-039 start mult, drop reset_n at t0+10 -> busy=0, hi=lo=0 immediately, no done pulse within 40 cycles.
